// File: rtl/clint_trap_ctrl.sv
// Machine-mode trap sequencer: takes timer interrupts, ECALL and MRET from execute,
// then walks SAVE -> UPDATE -> JUMP to update mepc/mcause/mstatus and redirect fetch.
module clint_trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic [63:0] ex_pc_i,
    input  logic        ex_ecall_i,
    input  logic        ex_mret_i,
    input  logic        mem_busy_i,
    input  logic [63:0] csr_mtvec_i,
    input  logic [63:0] csr_mepc_i,
    input  logic [63:0] csr_mstatus_i,
    input  logic        global_int_en_i,
    input  logic        mtime_int_en_i,
    input  logic        mtime_int_pend_i,
    output logic        clint_mepc_wen_o,
    output logic [63:0] clint_mepc_wdata_o,
    output logic        clint_mcause_wen_o,
    output logic [63:0] clint_mcause_wdata_o,
    output logic        clint_mstatus_wen_o,
    output logic [63:0] clint_mstatus_wdata_o,
    output logic        clint_stall_o,
    output logic        clint_redirect_o,
    output logic [63:0] clint_redirect_pc_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SAVE   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_JUMP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE  = 2'd0,
        KIND_INT   = 2'd1,
        KIND_ECALL = 2'd2,
        KIND_MRET  = 2'd3
    } kind_e;

    localparam logic [63:0] MCAUSE_MTI   = 64'h8000_0000_0000_0007;
    localparam logic [63:0] MCAUSE_ECALL = 64'd11;
    localparam int          MIE_BIT      = 3;
    localparam int          MPIE_BIT     = 7;

    state_e      state_q, state_d;
    kind_e       kind_q, kind_d;
    logic [63:0] pc_q, pc_d;

    logic int_req;
    logic ecall_req;
    logic mret_req;
    logic event_req;
    logic [63:0] mstatus_trap;
    logic [63:0] mstatus_mret;

    assign int_req   = ex_valid_i & global_int_en_i & mtime_int_en_i & mtime_int_pend_i;
    assign ecall_req = ex_valid_i & ex_ecall_i;
    assign mret_req  = ex_valid_i & ex_mret_i;
    assign event_req = (state_q == ST_IDLE) & (int_req | ecall_req | mret_req);

    always_comb begin
        mstatus_trap           = csr_mstatus_i;
        mstatus_trap[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
        mstatus_trap[MIE_BIT]  = 1'b0;
        mstatus_trap[12:11]    = 2'b11;

        mstatus_mret           = csr_mstatus_i;
        mstatus_mret[MIE_BIT]  = csr_mstatus_i[MPIE_BIT];
        mstatus_mret[MPIE_BIT] = 1'b1;
        mstatus_mret[12:11]    = 2'b11;
    end

    // NOTE: every signal assigned in this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        pc_d    = pc_q;

        clint_mepc_wen_o      = 1'b0;
        clint_mepc_wdata_o    = '0;
        clint_mcause_wen_o    = 1'b0;
        clint_mcause_wdata_o  = '0;
        clint_mstatus_wen_o   = 1'b0;
        clint_mstatus_wdata_o = '0;
        clint_redirect_o      = 1'b0;
        clint_redirect_pc_o   = '0;
        clint_stall_o         = (state_q != ST_IDLE) | event_req;

        case (state_q)
            ST_IDLE: begin
                if (event_req) begin
                    pc_d    = ex_pc_i;
                    kind_d  = int_req ? KIND_INT : (ecall_req ? KIND_ECALL : KIND_MRET);
                    state_d = mem_busy_i ? ST_WAIT : ST_SAVE;
                end
            end
            ST_WAIT: begin
                if (!mem_busy_i) state_d = ST_SAVE;
            end
            ST_SAVE: begin
                if (kind_q != KIND_MRET) begin
                    clint_mepc_wen_o     = 1'b1;
                    clint_mepc_wdata_o   = pc_q;
                    clint_mcause_wen_o   = 1'b1;
                    clint_mcause_wdata_o = (kind_q == KIND_INT) ? MCAUSE_MTI : MCAUSE_ECALL;
                end
                state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                clint_mstatus_wen_o   = 1'b1;
                clint_mstatus_wdata_o = (kind_q == KIND_MRET) ? mstatus_mret : mstatus_trap;
                state_d               = ST_JUMP;
            end
            ST_JUMP: begin
                clint_redirect_o    = 1'b1;
                clint_redirect_pc_o = (kind_q == KIND_MRET) ? csr_mepc_i
                                                            : (csr_mtvec_i & ~64'd3);
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A write issued in the same cycle as reset would land at the reset edge,
        // so reset suppresses every output immediately.
        if (rst) begin
            clint_mepc_wen_o      = 1'b0;
            clint_mepc_wdata_o    = '0;
            clint_mcause_wen_o    = 1'b0;
            clint_mcause_wdata_o  = '0;
            clint_mstatus_wen_o   = 1'b0;
            clint_mstatus_wdata_o = '0;
            clint_redirect_o      = 1'b0;
            clint_redirect_pc_o   = '0;
            clint_stall_o         = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its _d input regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            kind_q  <= KIND_NONE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Self-checking bench for clint_trap_ctrl: directed trap/return scenarios followed by
// randomized traffic, all compared against a cycle-count reference model.
module tb_clint_trap_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ex_valid_i;
    logic [63:0] ex_pc_i;
    logic        ex_ecall_i;
    logic        ex_mret_i;
    logic        mem_busy_i;
    logic [63:0] csr_mtvec_i;
    logic [63:0] csr_mepc_i;
    logic [63:0] csr_mstatus_i;
    logic        global_int_en_i;
    logic        mtime_int_en_i;
    logic        mtime_int_pend_i;
    logic        clint_mepc_wen_o;
    logic [63:0] clint_mepc_wdata_o;
    logic        clint_mcause_wen_o;
    logic [63:0] clint_mcause_wdata_o;
    logic        clint_mstatus_wen_o;
    logic [63:0] clint_mstatus_wdata_o;
    logic        clint_stall_o;
    logic        clint_redirect_o;
    logic [63:0] clint_redirect_pc_o;

    clint_trap_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .ex_valid_i            (ex_valid_i),
        .ex_pc_i               (ex_pc_i),
        .ex_ecall_i            (ex_ecall_i),
        .ex_mret_i             (ex_mret_i),
        .mem_busy_i            (mem_busy_i),
        .csr_mtvec_i           (csr_mtvec_i),
        .csr_mepc_i            (csr_mepc_i),
        .csr_mstatus_i         (csr_mstatus_i),
        .global_int_en_i       (global_int_en_i),
        .mtime_int_en_i        (mtime_int_en_i),
        .mtime_int_pend_i      (mtime_int_pend_i),
        .clint_mepc_wen_o      (clint_mepc_wen_o),
        .clint_mepc_wdata_o    (clint_mepc_wdata_o),
        .clint_mcause_wen_o    (clint_mcause_wen_o),
        .clint_mcause_wdata_o  (clint_mcause_wdata_o),
        .clint_mstatus_wen_o   (clint_mstatus_wen_o),
        .clint_mstatus_wdata_o (clint_mstatus_wdata_o),
        .clint_stall_o         (clint_stall_o),
        .clint_redirect_o      (clint_redirect_o),
        .clint_redirect_pc_o   (clint_redirect_pc_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: a pending trap is described by its kind and by how many
    // post-release cycles have elapsed (0 = still waiting for the bus).
    bit          m_active = 1'b0;
    int          m_stage  = 0;
    int          m_kind   = 0;   // 0 timer interrupt, 1 ecall, 2 mret
    logic [63:0] m_pc     = '0;

    function automatic bit m_int();
        return ex_valid_i && global_int_en_i && mtime_int_en_i && mtime_int_pend_i;
    endfunction

    function automatic bit m_event();
        return m_int() || (ex_valid_i && (ex_ecall_i || ex_mret_i));
    endfunction

    function automatic logic [63:0] m_mstatus(input int kind, input logic [63:0] m);
        logic [63:0] base;
        base = m & ~64'h1888;
        if (kind == 2) return base | 64'h1880 | ((m & 64'h80) != 0 ? 64'h8 : 64'h0);
        return base | 64'h1800 | ((m & 64'h8) != 0 ? 64'h80 : 64'h0);
    endfunction

    task automatic compare_outputs();
        logic        e_stall, e_mepc_wen, e_mcause_wen, e_mstatus_wen, e_redir;
        logic [63:0] e_mepc, e_mcause, e_mstatus, e_redir_pc;
        {e_stall, e_mepc_wen, e_mcause_wen, e_mstatus_wen, e_redir} = '0;
        {e_mepc, e_mcause, e_mstatus, e_redir_pc} = '0;
        if (!rst) begin
            if (!m_active) begin
                e_stall = m_event();
            end else begin
                e_stall = 1'b1;
                if (m_stage == 1 && m_kind != 2) begin
                    e_mepc_wen   = 1'b1;
                    e_mepc       = m_pc;
                    e_mcause_wen = 1'b1;
                    e_mcause     = (m_kind == 0) ? 64'h8000_0000_0000_0007 : 64'd11;
                end else if (m_stage == 2) begin
                    e_mstatus_wen = 1'b1;
                    e_mstatus     = m_mstatus(m_kind, csr_mstatus_i);
                end else if (m_stage == 3) begin
                    e_redir    = 1'b1;
                    e_redir_pc = (m_kind == 2) ? csr_mepc_i : (csr_mtvec_i / 4) * 4;
                end
            end
        end
        check("stall",        64'(clint_stall_o),       64'(e_stall));
        check("mepc_wen",     64'(clint_mepc_wen_o),    64'(e_mepc_wen));
        check("mepc_wdata",   clint_mepc_wdata_o,       e_mepc);
        check("mcause_wen",   64'(clint_mcause_wen_o),  64'(e_mcause_wen));
        check("mcause_wdata", clint_mcause_wdata_o,     e_mcause);
        check("mstatus_wen",  64'(clint_mstatus_wen_o), 64'(e_mstatus_wen));
        check("mstatus_wdata",clint_mstatus_wdata_o,    e_mstatus);
        check("redirect",     64'(clint_redirect_o),    64'(e_redir));
        check("redirect_pc",  clint_redirect_pc_o,      e_redir_pc);
    endtask

    task automatic model_update();
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (m_event()) begin
                m_active = 1'b1;
                m_pc     = ex_pc_i;
                m_kind   = m_int() ? 0 : (ex_ecall_i ? 1 : 2);
                m_stage  = mem_busy_i ? 0 : 1;
            end
        end else if (m_stage == 0) begin
            if (!mem_busy_i) m_stage = 1;
        end else if (m_stage == 3) begin
            m_active = 1'b0;
        end else begin
            m_stage++;
        end
    endtask

    task automatic settle_and_check();
        #1;
        compare_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst              = 1'b0;
        ex_valid_i       = 1'b0;
        ex_pc_i          = '0;
        ex_ecall_i       = 1'b0;
        ex_mret_i        = 1'b0;
        mem_busy_i       = 1'b0;
        global_int_en_i  = 1'b0;
        mtime_int_en_i   = 1'b0;
        mtime_int_pend_i = 1'b0;
    endtask

    task automatic random_inputs();
        rst              = ($urandom_range(0, 39) == 0);
        ex_valid_i       = ($urandom_range(0, 9) < 7);
        ex_pc_i          = {$urandom(), $urandom()};
        ex_ecall_i       = ($urandom_range(0, 9) < 3);
        ex_mret_i        = ($urandom_range(0, 9) < 3);
        mem_busy_i       = ($urandom_range(0, 9) < 3);
        csr_mtvec_i      = {$urandom(), $urandom()};
        csr_mepc_i       = {$urandom(), $urandom()};
        csr_mstatus_i    = {$urandom(), $urandom()};
        global_int_en_i  = ($urandom_range(0, 1) == 1);
        mtime_int_en_i   = ($urandom_range(0, 1) == 1);
        mtime_int_pend_i = ($urandom_range(0, 1) == 1);
    endtask

    initial begin
        idle_inputs();
        csr_mtvec_i   = '0;
        csr_mepc_i    = '0;
        csr_mstatus_i = '0;
        rst           = 1'b1;
        @(negedge clk);
        settle_and_check();
        advance();
        rst = 1'b0;
        settle_and_check();
        check("reset_stall", 64'(clint_stall_o), 64'd0);

        // ECALL, no bus activity
        ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 64'h8000_0100;
        csr_mtvec_i = 64'h8000_0003; csr_mstatus_i = 64'h1888;
        settle_and_check();
        check("ecall_stall_T", 64'(clint_stall_o), 64'd1);
        advance();
        ex_valid_i = 1'b0; ex_ecall_i = 1'b0;
        settle_and_check();
        check("ecall_mepc", clint_mepc_wdata_o, 64'h8000_0100);
        check("ecall_mcause", clint_mcause_wdata_o, 64'd11);
        advance();
        settle_and_check();
        check("ecall_mstatus", clint_mstatus_wdata_o, 64'h1880);
        advance();
        settle_and_check();
        check("ecall_redirect_pc", clint_redirect_pc_o, 64'h8000_0000);
        advance();
        settle_and_check();

        // Timer interrupt beats a coincident ECALL
        ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 64'h8000_0200;
        global_int_en_i = 1'b1; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
        settle_and_check();
        advance();
        idle_inputs();
        settle_and_check();
        check("int_mcause", clint_mcause_wdata_o, 64'h8000_0000_0000_0007);
        check("int_mepc", clint_mepc_wdata_o, 64'h8000_0200);
        for (int i = 0; i < 3; i++) begin
            advance();
            settle_and_check();
        end

        // MRET
        ex_valid_i = 1'b1; ex_mret_i = 1'b1; ex_pc_i = 64'h8000_0300;
        csr_mepc_i = 64'h8000_0204; csr_mstatus_i = 64'h1880;
        settle_and_check();
        advance();
        idle_inputs();
        settle_and_check();
        check("mret_no_mepc", 64'(clint_mepc_wen_o), 64'd0);
        check("mret_no_mcause", 64'(clint_mcause_wen_o), 64'd0);
        advance();
        settle_and_check();
        check("mret_mstatus", clint_mstatus_wdata_o, 64'h1888);
        advance();
        settle_and_check();
        check("mret_redirect", 64'(clint_redirect_o), 64'd1);
        check("mret_redirect_pc", clint_redirect_pc_o, 64'h8000_0204);
        advance();

        // ECALL held off by three busy cycles
        ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 64'h8000_0400; mem_busy_i = 1'b1;
        csr_mstatus_i = 64'h1888;
        for (int i = 0; i < 3; i++) begin
            settle_and_check();
            check("busy_stall", 64'(clint_stall_o), 64'd1);
            check("busy_no_write", 64'(clint_mepc_wen_o), 64'd0);
            advance();
            ex_valid_i = 1'b0; ex_ecall_i = 1'b0;
        end
        mem_busy_i = 1'b0;
        settle_and_check();
        check("busy_release_no_write", 64'(clint_mepc_wen_o), 64'd0);
        advance();
        settle_and_check();
        check("busy_save", 64'(clint_mepc_wen_o), 64'd1);
        advance();
        settle_and_check();
        check("busy_update", 64'(clint_mstatus_wen_o), 64'd1);
        advance();
        settle_and_check();
        check("busy_jump", 64'(clint_redirect_o), 64'd1);
        advance();

        // Reset while in UPDATE aborts the sequence
        ex_valid_i = 1'b1; ex_ecall_i = 1'b1; ex_pc_i = 64'h8000_0500;
        settle_and_check();
        advance();
        idle_inputs();
        settle_and_check();
        advance();
        rst = 1'b1;
        settle_and_check();
        check("rst_upd_no_mstatus", 64'(clint_mstatus_wen_o), 64'd0);
        advance();
        rst = 1'b0;
        settle_and_check();
        check("rst_upd_no_redirect", 64'(clint_redirect_o), 64'd0);
        check("rst_upd_stall", 64'(clint_stall_o), 64'd0);
        advance();
        settle_and_check();
        check("rst_upd_idle", 64'(clint_stall_o | clint_mstatus_wen_o | clint_redirect_o), 64'd0);

        // Pending timer with interrupts globally disabled is ignored
        ex_valid_i = 1'b1; mtime_int_en_i = 1'b1; mtime_int_pend_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            settle_and_check();
            check("masked_int_quiet",
                  64'(clint_stall_o | clint_mepc_wen_o | clint_mstatus_wen_o | clint_redirect_o),
                  64'd0);
            advance();
        end

        for (int i = 0; i < 3000; i++) begin
            random_inputs();
            settle_and_check();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
